// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared defaults, unity-gain constant, gain FSM state type and
//             RGB pixel type for the white-balance gain-apply block.
//  Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int c_PIX_W     = 8;
    localparam int c_GAIN_W    = 16;
    localparam int c_FRAC_BITS = 8;

    // Unity gain in the default fixed-point format (1.0 = 1 << c_FRAC_BITS)
    localparam logic [c_GAIN_W-1:0] c_GAIN_UNITY = 16'h0100;

    // Gain set life cycle: power-on unity, captured-but-waiting, in use
    typedef enum logic [1:0] {
        UNITY   = 2'd0,
        PENDING = 2'd1,
        ACTIVE  = 2'd2
    } gain_state_t;

    typedef struct packed {
        logic [c_PIX_W-1:0] r;
        logic [c_PIX_W-1:0] g;
        logic [c_PIX_W-1:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/wb_chan_scale.sv
`default_nettype none
// ============================================================================
//  Module   : wb_chan_scale
//  Purpose  : One colour channel: S1 registers pix*K, S2 rounds half-up,
//             saturates to PIX_W bits and registers the result.
//             With WB_CLIP_CNT_EN, o_sat flags that the product currently
//             held in S1 will saturate when it moves into S2.
//  Revision : 1.0  initial release
// ============================================================================
module wb_chan_scale
    import wb_pkg::*;
#(
    parameter int PIX_W     = c_PIX_W,
    parameter int GAIN_W    = c_GAIN_W,
    parameter int FRAC_BITS = c_FRAC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_s1_ld,
    input  logic                i_s2_ld,
    input  logic [PIX_W-1:0]    i_pix,
    input  logic [GAIN_W-1:0]   i_gain,
`ifdef WB_CLIP_CNT_EN
    output logic                o_sat,
`endif
    output logic [PIX_W-1:0]    o_pix
);

    localparam int c_PW = PIX_W + GAIN_W;      // full product width
    localparam int c_SW = c_PW + 1;            // product + rounding carry
    localparam int c_YW = c_SW - FRAC_BITS;    // integer part after shift
    localparam logic [c_SW-1:0] c_HALF = c_SW'(1) << (FRAC_BITS - 1);

    logic [c_PW-1:0]  r_prod;
    logic [PIX_W-1:0] r_pix;
    logic [c_SW-1:0]  w_sum;
    logic [c_YW-1:0]  w_y;
    logic             w_sat;

    // Round half up, then any bit above PIX_W means the result overflows
    assign w_sum = {1'b0, r_prod} + c_HALF;
    assign w_y   = c_YW'(w_sum >> FRAC_BITS);
    assign w_sat = |w_y[c_YW-1:PIX_W];

    // S1: capture the full-precision product of an accepted pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (i_s1_ld) begin
            r_prod <= {{GAIN_W{1'b0}}, i_pix} * {{PIX_W{1'b0}}, i_gain};
        end
    end

    // S2: register the rounded, saturated channel value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix <= '0;
        end else if (i_s2_ld) begin
            r_pix <= w_sat ? {PIX_W{1'b1}} : w_y[PIX_W-1:0];
        end
    end

    assign o_pix = r_pix;
`ifdef WB_CLIP_CNT_EN
    assign o_sat = w_sat;
`endif

endmodule
`default_nettype wire

// File: rtl/wb_gain_apply.sv
`default_nettype none
// ============================================================================
//  Module   : wb_gain_apply
//  Purpose  : Captures white-balance gains from the gain calculator and
//             applies them to a valid/ready RGB stream through a two-stage
//             pipeline. New gains switch in only on an accepted SOF pixel.
//             Optional macro WB_CLIP_CNT_EN adds clip_cnt_o, the number of
//             pixels in the current frame with at least one clipped channel.
//  Revision : 1.0  initial release
// ============================================================================
module wb_gain_apply
    import wb_pkg::*;
#(
    parameter int PIX_W     = c_PIX_W,
    parameter int GAIN_W    = c_GAIN_W,
    parameter int FRAC_BITS = c_FRAC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_gain_i,
    input  logic [GAIN_W-1:0]   K_R_i,
    input  logic [GAIN_W-1:0]   K_G_i,
    input  logic [GAIN_W-1:0]   K_B_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_sof_i,
    input  logic [PIX_W-1:0]    in_r_i,
    input  logic [PIX_W-1:0]    in_g_i,
    input  logic [PIX_W-1:0]    in_b_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_sof_o,
    output logic [PIX_W-1:0]    out_r_o,
    output logic [PIX_W-1:0]    out_g_o,
    output logic [PIX_W-1:0]    out_b_o,
`ifdef WB_CLIP_CNT_EN
    output logic [15:0]         clip_cnt_o,
`endif
    output logic                gain_pending_o
);

    localparam logic [GAIN_W-1:0] c_UNITY = GAIN_W'(1) << FRAC_BITS;

    gain_state_t       r_state, w_state_nxt;
    logic              w_apply;
    logic [GAIN_W-1:0] r_kp_r, r_kp_g, r_kp_b;   // pending set
    logic [GAIN_W-1:0] r_ka_r, r_ka_g, r_ka_b;   // active set
    logic [GAIN_W-1:0] w_k_r, w_k_g, w_k_b;      // gains for the pixel entering S1
    logic              r_v1, r_v2, r_sof1, r_sof2;
    logic              w_s1_en, w_s2_en, w_acc, w_sof_acc, w_s2_ld;

    // Elastic two-stage pipeline: a stage may load when empty or draining
    assign w_s2_en    = !r_v2 || out_ready_i;
    assign w_s1_en    = !r_v1 || w_s2_en;
    assign in_ready_o = w_s1_en;
    assign w_acc      = in_valid_i && w_s1_en;
    assign w_sof_acc  = w_acc && in_sof_i;
    assign w_s2_ld    = w_s2_en && r_v1;

    // Gain FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= UNITY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a new pulse always leaves a set pending; a pending set is
    // promoted by the first accepted SOF (the same pixel uses it)
    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        if (r_state == PENDING && w_sof_acc) begin
            w_apply = 1'b1;
        end
        if (valid_gain_i) begin
            w_state_nxt = PENDING;
        end else if (w_apply) begin
            w_state_nxt = ACTIVE;
        end
    end

    assign gain_pending_o = (r_state == PENDING);

    // Pending/active gain registers; promotion reads the old pending value,
    // so a simultaneous pulse queues behind the set being applied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kp_r <= c_UNITY;
            r_kp_g <= c_UNITY;
            r_kp_b <= c_UNITY;
            r_ka_r <= c_UNITY;
            r_ka_g <= c_UNITY;
            r_ka_b <= c_UNITY;
        end else begin
            if (valid_gain_i) begin
                r_kp_r <= K_R_i;
                r_kp_g <= K_G_i;
                r_kp_b <= K_B_i;
            end
            if (w_apply) begin
                r_ka_r <= r_kp_r;
                r_ka_g <= r_kp_g;
                r_ka_b <= r_kp_b;
            end
        end
    end

    assign w_k_r = w_apply ? r_kp_r : r_ka_r;
    assign w_k_g = w_apply ? r_kp_g : r_ka_g;
    assign w_k_b = w_apply ? r_kp_b : r_ka_b;

    // Stage valids and SOF travel alongside the channel data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_sof1 <= 1'b0;
            r_sof2 <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_v1   <= w_acc;
                r_sof1 <= w_sof_acc;
            end
            if (w_s2_en) begin
                r_v2   <= r_v1;
                r_sof2 <= r_sof1;
            end
        end
    end

    assign out_valid_o = r_v2;
    assign out_sof_o   = r_sof2;

`ifdef WB_CLIP_CNT_EN
    logic        w_sat_r, w_sat_g, w_sat_b, w_any_sat;
    logic [15:0] r_clip;
`endif

    wb_chan_scale #(.PIX_W(PIX_W), .GAIN_W(GAIN_W), .FRAC_BITS(FRAC_BITS)) u_chan_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_s1_ld (w_acc),
        .i_s2_ld (w_s2_ld),
        .i_pix   (in_r_i),
        .i_gain  (w_k_r),
`ifdef WB_CLIP_CNT_EN
        .o_sat   (w_sat_r),
`endif
        .o_pix   (out_r_o)
    );

    wb_chan_scale #(.PIX_W(PIX_W), .GAIN_W(GAIN_W), .FRAC_BITS(FRAC_BITS)) u_chan_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_s1_ld (w_acc),
        .i_s2_ld (w_s2_ld),
        .i_pix   (in_g_i),
        .i_gain  (w_k_g),
`ifdef WB_CLIP_CNT_EN
        .o_sat   (w_sat_g),
`endif
        .o_pix   (out_g_o)
    );

    wb_chan_scale #(.PIX_W(PIX_W), .GAIN_W(GAIN_W), .FRAC_BITS(FRAC_BITS)) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_s1_ld (w_acc),
        .i_s2_ld (w_s2_ld),
        .i_pix   (in_b_i),
        .i_gain  (w_k_b),
`ifdef WB_CLIP_CNT_EN
        .o_sat   (w_sat_b),
`endif
        .o_pix   (out_b_o)
    );

`ifdef WB_CLIP_CNT_EN
    assign w_any_sat = w_sat_r || w_sat_g || w_sat_b;

    // Per-frame clipped-pixel count, restarted by the SOF pixel itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clip <= 16'd0;
        end else if (w_s2_ld) begin
            if (r_sof1) begin
                r_clip <= {15'd0, w_any_sat};
            end else if (w_any_sat && r_clip != 16'hFFFF) begin
                r_clip <= r_clip + 16'd1;
            end
        end
    end

    assign clip_cnt_o = r_clip;
`endif

endmodule
`default_nettype wire
